cpsr_flag_stack: RTL and testbench

- Parametrised successor to the 3-bit status register.
- Holds FLAG_W condition flags with per-flag masked update and a software write path.
- Adds a LIFO save/restore stack of depth STACK_DEPTH for interrupt/call entry and exit.
- Evaluates a 4-bit branch condition code against the current flags for the control unit.

---
 rtl/cpsr_pkg.sv | 11 +
 rtl/flag_stack.sv | 44 ++++
 rtl/cpsr_flag_stack.sv | 79 +++++++
 tb/tb_cpsr_flag_stack.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/cpsr_pkg.sv
// cpsr_pkg: flag bit positions and branch condition codes shared by the flag logic
package cpsr_pkg;
  localparam int FLAG_Z = 0;
  localparam int FLAG_V = 1;
  localparam int FLAG_N = 2;
  localparam int FLAG_C = 3;
  typedef enum logic [3:0] {
    CC_EQ, CC_NE, CC_MI, CC_PL, CC_VS, CC_VC, CC_CS, CC_CC,
    CC_HI, CC_LS, CC_GE, CC_LT, CC_GT, CC_LE, CC_AL, CC_NV
  } cond_code_t;
endpackage

// File: rtl/flag_stack.sv
// flag_stack: saturating LIFO of flag words with push+pop swapping the top entry
module flag_stack #(
  parameter int FLAG_W = 4,
  parameter int STACK_DEPTH = 4,
  localparam int DW = $clog2(STACK_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [FLAG_W-1:0] din,
  output logic [FLAG_W-1:0] top,
  output logic [DW-1:0]     depth_cnt,
  output logic              full,
  output logic              empty,
  output logic              ovf_pulse,
  output logic              unf_pulse
);
  logic [FLAG_W-1:0] mem_q [STACK_DEPTH];
  logic [FLAG_W-1:0] mem_d [STACK_DEPTH];
  logic [DW-1:0] depth_q, depth_d, wr_idx;
  logic swap, do_push, do_pop;
  assign full = depth_q == DW'(STACK_DEPTH);
  assign empty = depth_q == '0;
  assign depth_cnt = depth_q;
  assign swap = push & pop & ~empty;
  assign do_push = push & ~pop & ~full;
  assign do_pop = pop & ~push & ~empty;
  assign ovf_pulse = push & ~pop & full;
  assign unf_pulse = pop & empty;
  always_comb begin
    wr_idx = swap ? depth_q - DW'(1) : depth_q;
    depth_d = do_push ? depth_q + DW'(1) : do_pop ? depth_q - DW'(1) : depth_q;
    mem_d = mem_q;
    top = '0;
    for (int i = 0; i < STACK_DEPTH; i++) begin
      if ((swap | do_push) && DW'(i) == wr_idx) mem_d[i] = din;
      if (DW'(i + 1) == depth_q) top = mem_q[i];
    end
  end
  always_ff @(posedge clk) depth_q <= rst ? '0 : depth_d;
  // Contents need no reset: entries at or above depth_cnt are never read
  always_ff @(posedge clk) mem_q <= mem_d;
endmodule

// File: rtl/cpsr_flag_stack.sv
// cpsr_flag_stack: condition flag register with masked update, save/restore stack and branch evaluation
module cpsr_flag_stack
  import cpsr_pkg::*;
#(
  parameter int FLAG_W = 4,
  parameter int STACK_DEPTH = 4,
  localparam int DW = $clog2(STACK_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [FLAG_W-1:0] flags_in,
  input  logic              upd_en,
  input  logic [FLAG_W-1:0] upd_mask,
  input  logic              wr_en,
  input  logic [FLAG_W-1:0] wr_data,
  input  logic              push,
  input  logic              pop,
  input  logic              err_clr,
  input  logic [3:0]        cond,
  output logic [FLAG_W-1:0] flags_out,
  output logic              cond_true,
  output logic [DW-1:0]     depth_cnt,
  output logic              stack_full,
  output logic              stack_empty,
  output logic              err_overflow,
  output logic              err_underflow
);
  logic [FLAG_W-1:0] flags_q, flags_d, top;
  logic ovf_q, ovf_d, unf_q, unf_d, ovf_pulse, unf_pulse;
  logic z, v, n, c;
  flag_stack #(.FLAG_W(FLAG_W), .STACK_DEPTH(STACK_DEPTH)) u_stack (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .din(flags_q),
    .top(top), .depth_cnt(depth_cnt), .full(stack_full), .empty(stack_empty),
    .ovf_pulse(ovf_pulse), .unf_pulse(unf_pulse)
  );
  // A push+pop on an empty stack holds the flags and suppresses software/ALU writes
  always_comb begin
    flags_d = (pop & ~stack_empty) ? top :
              (push & pop)         ? flags_q :
              wr_en                ? wr_data :
              upd_en               ? (flags_q & ~upd_mask) | (flags_in & upd_mask) :
                                     flags_q;
    ovf_d = ovf_pulse | (ovf_q & ~err_clr);
    unf_d = unf_pulse | (unf_q & ~err_clr);
  end
  always_ff @(posedge clk) begin
    flags_q <= rst ? '0 : flags_d;
    ovf_q <= rst ? 1'b0 : ovf_d;
    unf_q <= rst ? 1'b0 : unf_d;
  end
  assign flags_out = flags_q;
  assign err_overflow = ovf_q;
  assign err_underflow = unf_q;
  assign z = flags_q[FLAG_Z];
  assign v = flags_q[FLAG_V];
  assign n = flags_q[FLAG_N];
  assign c = flags_q[FLAG_C];
  always_comb begin
    cond_true = 1'b0;
    case (cond_code_t'(cond))
      CC_EQ: cond_true = z;
      CC_NE: cond_true = ~z;
      CC_MI: cond_true = n;
      CC_PL: cond_true = ~n;
      CC_VS: cond_true = v;
      CC_VC: cond_true = ~v;
      CC_CS: cond_true = c;
      CC_CC: cond_true = ~c;
      CC_HI: cond_true = c & ~z;
      CC_LS: cond_true = ~c | z;
      CC_GE: cond_true = n == v;
      CC_LT: cond_true = n != v;
      CC_GT: cond_true = ~z & (n == v);
      CC_LE: cond_true = z | (n != v);
      CC_AL: cond_true = 1'b1;
      default: cond_true = 1'b0;
    endcase
  end
endmodule

// File: tb/tb_cpsr_flag_stack.sv
// tb_cpsr_flag_stack: directed vectors checked against a queue-based reference model every cycle
module tb_cpsr_flag_stack;
  localparam int W = 4;
  localparam int D = 4;
  localparam int DW = $clog2(D + 1);
  logic clk = 0, rst, upd_en, wr_en, push, pop, err_clr;
  logic [W-1:0] flags_in, upd_mask, wr_data, flags_out;
  logic [3:0] cond;
  logic cond_true, stack_full, stack_empty, err_overflow, err_underflow;
  logic [DW-1:0] depth_cnt;
  int checks = 0, failures = 0;
  int m_flags, m_ovf, m_unf;
  int m_stk[$];
  bit m_valid = 0;

  cpsr_flag_stack #(.FLAG_W(W), .STACK_DEPTH(D)) dut (
    .clk(clk), .rst(rst), .flags_in(flags_in), .upd_en(upd_en), .upd_mask(upd_mask),
    .wr_en(wr_en), .wr_data(wr_data), .push(push), .pop(pop), .err_clr(err_clr),
    .cond(cond), .flags_out(flags_out), .cond_true(cond_true), .depth_cnt(depth_cnt),
    .stack_full(stack_full), .stack_empty(stack_empty),
    .err_overflow(err_overflow), .err_underflow(err_underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int cond_eval(input int f, input int cc);
    int z, v, n, c;
    z = f & 1; v = (f >> 1) & 1; n = (f >> 2) & 1; c = (f >> 3) & 1;
    case (cc)
      0: return z;           1: return 1 - z;
      2: return n;           3: return 1 - n;
      4: return v;           5: return 1 - v;
      6: return c;           7: return 1 - c;
      8: return (c == 1 && z == 0) ? 1 : 0;
      9: return (c == 0 || z == 1) ? 1 : 0;
      10: return (n == v) ? 1 : 0;
      11: return (n != v) ? 1 : 0;
      12: return (z == 0 && n == v) ? 1 : 0;
      13: return (z == 1 || n != v) ? 1 : 0;
      14: return 1;
      default: return 0;
    endcase
  endfunction

  always @(posedge clk) begin
    int nf, e, so, su;
    if (rst) begin
      m_flags = 0; m_ovf = 0; m_unf = 0; m_stk.delete();
    end else begin
      nf = m_flags; e = m_stk.size(); so = 0; su = 0;
      if (push && pop) begin
        if (e > 0) begin nf = m_stk[e-1]; m_stk[e-1] = m_flags; end
        else su = 1;
      end else begin
        if (pop && e > 0) nf = m_stk.pop_back();
        else begin
          if (pop) su = 1;
          if (wr_en) nf = wr_data;
          else if (upd_en) nf = (m_flags & ~int'(upd_mask)) | (int'(flags_in) & int'(upd_mask));
        end
        if (push) begin
          if (e == D) so = 1;
          else m_stk.push_back(m_flags);
        end
      end
      m_flags = nf & 'hF;
      m_ovf = (so == 1 || (m_ovf == 1 && !err_clr)) ? 1 : 0;
      m_unf = (su == 1 || (m_unf == 1 && !err_clr)) ? 1 : 0;
    end
    m_valid = 1;
  end

  always @(negedge clk) if (m_valid) begin
    chk("m_flags", int'(flags_out), m_flags);
    chk("m_depth", int'(depth_cnt), m_stk.size());
    chk("m_full", int'(stack_full), (m_stk.size() == D) ? 1 : 0);
    chk("m_empty", int'(stack_empty), (m_stk.size() == 0) ? 1 : 0);
    chk("m_ovf", int'(err_overflow), m_ovf);
    chk("m_unf", int'(err_underflow), m_unf);
    chk("m_cond", int'(cond_true), cond_eval(m_flags, int'(cond)));
  end

  task automatic clr();
    rst = 0; upd_en = 0; wr_en = 0; push = 0; pop = 0; err_clr = 0;
    flags_in = '0; upd_mask = '0; wr_data = '0;
  endtask

  task automatic tick();
    @(posedge clk); #1; clr();
  endtask

  task automatic upd(input logic [3:0] v, input logic [3:0] m);
    upd_en = 1; flags_in = v; upd_mask = m;
  endtask

  initial begin
    clr(); cond = 0; rst = 1;
    tick();
    chk("rst_flags", int'(flags_out), 0);
    chk("rst_depth", int'(depth_cnt), 0);
    upd(4'b0101, 4'hF); tick();
    chk("upd_flags", int'(flags_out), 5);
    cond = 0; #1 chk("cond_eq", int'(cond_true), 1);
    cond = 11; #1 chk("cond_lt", int'(cond_true), 1);
    cond = 8; #1 chk("cond_hi", int'(cond_true), 0);
    upd(4'hF, 4'hF); tick();
    upd(4'h0, 4'b0011); tick();
    chk("masked", int'(flags_out), 4'b1100);
    upd(4'b0001, 4'hF); tick();
    push = 1; upd(4'b1000, 4'hF); tick();
    chk("push_upd_flags", int'(flags_out), 4'b1000);
    chk("push_upd_depth", int'(depth_cnt), 1);
    pop = 1; tick();
    chk("pop_flags", int'(flags_out), 4'b0001);
    chk("pop_empty", int'(stack_empty), 1);
    for (int i = 0; i < 5; i++) begin
      push = 1; wr_en = 1; wr_data = 4'(i + 2); tick();
    end
    chk("ovf_depth", int'(depth_cnt), 4);
    chk("ovf_full", int'(stack_full), 1);
    chk("ovf_err", int'(err_overflow), 1);
    chk("ovf_flags", int'(flags_out), 6);
    for (int i = 0; i < 4; i++) begin
      pop = 1; tick();
      chk("lifo", int'(flags_out), 4 - i);
    end
    err_clr = 1; tick();
    chk("ovf_clr", int'(err_overflow), 0);
    pop = 1; upd(4'b0010, 4'hF); tick();
    chk("unf_err", int'(err_underflow), 1);
    chk("unf_flags", int'(flags_out), 2);
    pop = 1; err_clr = 1; tick();
    chk("set_beats_clr", int'(err_underflow), 1);
    wr_en = 1; wr_data = 4'b0100; tick();
    push = 1; wr_en = 1; wr_data = 4'b0010; tick();
    push = 1; pop = 1; wr_en = 1; wr_data = 4'hF; tick();
    chk("swap_flags", int'(flags_out), 4'b0100);
    chk("swap_depth", int'(depth_cnt), 1);
    pop = 1; tick();
    chk("swap_top", int'(flags_out), 4'b0010);
    err_clr = 1; tick();
    push = 1; pop = 1; upd(4'hF, 4'hF); tick();
    chk("swap_empty_flags", int'(flags_out), 4'b0010);
    chk("swap_empty_unf", int'(err_underflow), 1);
    for (int i = 0; i < 3; i++) begin
      push = 1; wr_en = 1; wr_data = 4'(9 + i); tick();
    end
    rst = 1; push = 1; upd(4'hF, 4'hF); tick();
    chk("mrst_flags", int'(flags_out), 0);
    chk("mrst_depth", int'(depth_cnt), 0);
    chk("mrst_errs", int'({err_overflow, err_underflow}), 0);
    pop = 1; tick();
    chk("mrst_unf", int'(err_underflow), 1);
    for (int cc = 0; cc < 16; cc++) begin
      cond = 4'(cc); wr_en = 1; wr_data = 4'(cc * 7); tick();
    end
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
